spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_bit_cnt.sv | 29 ++
 rtl/spi_xfer_ctrl.sv | 107 ++++++++++
 tb/tb_spi_xfer_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI transfer controller slice.
//   state_t      - transfer FSM states
//   CNT_W_DEF    - default bit-counter width (holds 0..64)
//   MAX_LEN_DEF  - default maximum transfer length; char_len==0 encodes it
//   EDGE_POS/NEG - edge-select encodings for tx_negedge / rx_negedge
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, FINISH} state_t;

  localparam int CNT_W_DEF   = 7;
  localparam int MAX_LEN_DEF = 64;

  localparam logic EDGE_POS = 1'b0;
  localparam logic EDGE_NEG = 1'b1;
endpackage

// File: rtl/spi_bit_cnt.sv
// spi_bit_cnt: down-counter of bits remaining in a transfer.
//   wb_clk_in, wb_rst      - clock, async active-high reset
//   clr                    - clear to 0 (highest priority)
//   load, load_val         - load transfer length
//   dec                    - decrement by one
//   cnt, cnt_one, cnt_zero - count and its ==1 / ==0 flags
module spi_bit_cnt #(
  parameter int CNT_W = spi_pkg::CNT_W_DEF
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_one,
  output logic             cnt_zero
);
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - CNT_W'(1);
  end

  assign cnt_one  = (cnt == CNT_W'(1));
  assign cnt_zero = (cnt == '0);
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sequences one SPI transfer of char_len bits against the
// pos_edge/neg_edge strobes of an external SPI clock generator.
//   wb_clk_in, wb_rst        - clock, async active-high reset
//   go, abort                - start (IDLE only) / cancel from any state
//   char_len                 - bits per transfer, 0 means MAX_LEN
//   tx_negedge, rx_negedge   - strobe selection for launch / sample
//   ass                      - automatic slave-select enable
//   pos_edge, neg_edge       - clock generator strobes
//   tip, last_clk            - clock generator enable / stop qualifier
//   bit_idx                  - bits sampled so far in this transfer
//   tx_shift, rx_sample      - data shifter strobes
//   ss_active, done          - slave-select request / completion pulse
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst,
  input  logic             go,
  input  logic             abort,
  input  logic [5:0]       char_len,
  input  logic             tx_negedge,
  input  logic             rx_negedge,
  input  logic             ass,
  input  logic             pos_edge,
  input  logic             neg_edge,
  output logic             tip,
  output logic             last_clk,
  output logic [CNT_W-1:0] bit_idx,
  output logic             tx_shift,
  output logic             rx_sample,
  output logic             ss_active,
  output logic             done
);
  state_t           state, nxt;
  logic [CNT_W-1:0] len, len_in, cnt;
  logic             cnt_one, cnt_zero;
  logic             load, dec, clr;
  logic             rx_edge, tx_edge;

  assign len_in  = (char_len == '0) ? CNT_W'(MAX_LEN) : CNT_W'(char_len);
  assign rx_edge = (rx_negedge == EDGE_NEG) ? neg_edge : pos_edge;
  assign tx_edge = (tx_negedge == EDGE_NEG) ? neg_edge : pos_edge;

  spi_bit_cnt #(.CNT_W(CNT_W)) u_cnt (
    .wb_clk_in (wb_clk_in),
    .wb_rst    (wb_rst),
    .clr       (clr),
    .load      (load),
    .load_val  (len_in),
    .dec       (dec),
    .cnt       (cnt),
    .cnt_one   (cnt_one),
    .cnt_zero  (cnt_zero)
  );

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
      len   <= '0;
    end else begin
      state <= nxt;
      if (load) len <= len_in;
    end
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    dec  = 1'b0;
    clr  = 1'b0;
    if (abort) begin
      nxt = IDLE;
      clr = 1'b1;
    end else begin
      unique case (state)
        IDLE:   if (go) begin
                  nxt  = SETUP;
                  load = 1'b1;
                end
        SETUP:  nxt = XFER;
        XFER:   if (rx_edge) begin
                  dec = 1'b1;
                  if (cnt_one) nxt = FINISH;
                end
        FINISH: nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // All status outputs decode the state register, so the async reset of
  // state drops them without waiting for a clock.
  assign tip       = (state == XFER);
  assign last_clk  = (state == XFER) & cnt_one;
  assign done      = (state == FINISH);
  assign ss_active = ass & (state != IDLE);
  assign rx_sample = (state == XFER) & rx_edge;
  assign tx_shift  = (state == XFER) & tx_edge;
  // len is stale in IDLE after a transfer, so force 0 there.
  assign bit_idx   = (state == IDLE) ? '0 : (len - cnt);

  logic unused_ok;
  assign unused_ok = cnt_zero;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed bench for spi_xfer_ctrl with hand-derived
// expected values; inputs change 1 ns after the rising edge.
module tb_spi_xfer_ctrl;
  logic       wb_clk_in = 1'b0;
  logic       wb_rst = 1'b1;
  logic       go = 0, abort = 0, tx_negedge = 0, rx_negedge = 0, ass = 0;
  logic       pos_edge = 0, neg_edge = 0;
  logic [5:0] char_len = '0;
  logic       tip, last_clk, tx_shift, rx_sample, ss_active, done;
  logic [6:0] bit_idx;

  int n_chk = 0, n_fail = 0;
  int rx_tot = 0, tx_tot = 0, done_tot = 0, tip_tot = 0;
  int rx0, tx0, done0, tip0;

  always #5 wb_clk_in = ~wb_clk_in;

  spi_xfer_ctrl dut (
    .wb_clk_in (wb_clk_in), .wb_rst (wb_rst), .go (go), .abort (abort),
    .char_len (char_len), .tx_negedge (tx_negedge), .rx_negedge (rx_negedge),
    .ass (ass), .pos_edge (pos_edge), .neg_edge (neg_edge), .tip (tip),
    .last_clk (last_clk), .bit_idx (bit_idx), .tx_shift (tx_shift),
    .rx_sample (rx_sample), .ss_active (ss_active), .done (done)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge wb_clk_in) begin
    rx_tot   <= rx_tot + int'(rx_sample);
    tx_tot   <= tx_tot + int'(tx_shift);
    done_tot <= done_tot + int'(done);
    tip_tot  <= tip_tot + int'(tip);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One clock with the given strobes; returns 1 ns after the rising edge.
  task automatic cyc(input logic pe, input logic ne);
    pos_edge = pe;
    neg_edge = ne;
    @(posedge wb_clk_in);
    #1;
    pos_edge = 0;
    neg_edge = 0;
  endtask

  task automatic snap();
    rx0 = rx_tot; tx0 = tx_tot; done0 = done_tot; tip0 = tip_tot;
  endtask

  // go pulse, then through SETUP into XFER.
  task automatic start();
    go = 1;
    cyc(0, 0);
    go = 0;
    chk("setup_tip", int'(tip), 0);
    cyc(0, 0);
    chk("xfer_tip", int'(tip), 1);
  endtask

  initial begin
    #2;
    chk("rst_tip", int'(tip), 0);
    chk("rst_ss", int'(ss_active), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_last", int'(last_clk), 0);
    chk("rst_idx", int'(bit_idx), 0);
    @(posedge wb_clk_in); #1;
    wb_rst = 0;
    cyc(0, 0);

    // Normal 8-bit transfer: tx on neg_edge, rx on pos_edge.
    ass = 1; char_len = 6'd8; tx_negedge = 1; rx_negedge = 0;
    snap();
    start();
    chk("norm_ss", int'(ss_active), 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1);
      repeat (3) cyc(0, 0);
      chk($sformatf("norm_idx%0d", i), int'(bit_idx), i);
      if (i == 7) chk("norm_last", int'(last_clk), 1);
      else if (i == 6) chk("norm_nolast", int'(last_clk), 0);
      cyc(1, 0);
      if (i < 7) repeat (3) cyc(0, 0);
    end
    chk("norm_done", int'(done), 1);
    chk("norm_fin_tip", int'(tip), 0);
    cyc(0, 0);
    chk("norm_idle_done", int'(done), 0);
    chk("norm_idle_ss", int'(ss_active), 0);
    chk("norm_idle_idx", int'(bit_idx), 0);
    chk("norm_rx", rx_tot - rx0, 8);
    chk("norm_tx", tx_tot - tx0, 8);
    chk("norm_ndone", done_tot - done0, 1);
    chk("norm_tipcyc", tip_tot - tip0, 61);

    // Full length via char_len=0, both strobes each cycle.
    char_len = 6'd0; tx_negedge = 0; rx_negedge = 1;
    snap();
    start();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        chk("full_idx63", int'(bit_idx), 63);
        chk("full_last", int'(last_clk), 1);
      end
      cyc(1, 1);
      if (i < 63) cyc(0, 0);
    end
    chk("full_done", int'(done), 1);
    cyc(0, 0);
    chk("full_idx0", int'(bit_idx), 0);
    chk("full_rx", rx_tot - rx0, 64);
    chk("full_tx", tx_tot - tx0, 64);

    // Abort after the 3rd sample of a 16-bit transfer.
    char_len = 6'd16; tx_negedge = 0; rx_negedge = 1;
    snap();
    start();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      cyc(0, 1);
    end
    chk("abt_idx3", int'(bit_idx), 3);
    abort = 1;
    cyc(0, 0);
    abort = 0;
    chk("abt_tip", int'(tip), 0);
    chk("abt_ss", int'(ss_active), 0);
    chk("abt_idx", int'(bit_idx), 0);
    repeat (4) cyc(1, 1);
    chk("abt_rx", rx_tot - rx0, 3);
    chk("abt_tx", tx_tot - tx0, 3);
    chk("abt_ndone", done_tot - done0, 0);

    // go and abort together in IDLE.
    go = 1; abort = 1;
    repeat (2) cyc(0, 0);
    go = 0; abort = 0;
    chk("prio_ss", int'(ss_active), 0);
    chk("prio_tip", int'(tip), 0);

    // go held: 1-bit transfers back to back, len not relatched mid-transfer.
    char_len = 6'd1; rx_negedge = 0; go = 1;
    snap();
    cyc(0, 0);
    cyc(0, 0);
    chk("hold_tip1", int'(tip), 1);
    cyc(1, 0);
    chk("hold_done1", int'(done), 1);
    cyc(0, 0);
    chk("hold_idle_ss", int'(ss_active), 0);
    cyc(0, 0);
    char_len = 6'd5;
    chk("hold_setup_ss", int'(ss_active), 1);
    chk("hold_setup_tip", int'(tip), 0);
    cyc(0, 0);
    chk("hold_tip2", int'(tip), 1);
    cyc(1, 0);
    chk("hold_done2", int'(done), 1);
    go = 0;
    cyc(0, 0);
    chk("hold_ndone", done_tot - done0, 2);

    // Async reset while in XFER with last_clk high.
    char_len = 6'd8; rx_negedge = 0; tx_negedge = 1;
    snap();
    start();
    repeat (7) cyc(1, 0);
    chk("ar_last_pre", int'(last_clk), 1);
    #2 wb_rst = 1;
    #1;
    chk("ar_tip", int'(tip), 0);
    chk("ar_ss", int'(ss_active), 0);
    chk("ar_last", int'(last_clk), 0);
    chk("ar_idx", int'(bit_idx), 0);
    #1 wb_rst = 0;
    @(posedge wb_clk_in); #1;
    cyc(1, 0);
    chk("ar_idle_tip", int'(tip), 0);
    chk("ar_idle_ss", int'(ss_active), 0);
    chk("ar_ndone", done_tot - done0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
